expr_eval: RTL and testbench
============================

// Module: expr_eval
// PURPOSE
//  Arithmetic evaluator stage for the single-digit expression stream ("d{[+*]d}").
//  - Consumes the same ASCII character stream that the expr validator checks.
//  - Computes the integer value of the prefix seen so far, with '*' binding tighter than '+'.
//  - Flags legality on its own, so it can stand in for the validator or run alongside it.
// PARAMETERS
//  W  32  width of the value datapath and of the val output; all arithmetic is mod 2^W
// PORTS
//  clk     in   1  system clock, rising edge
//  clr     in   1  asynchronous active-high reset; returns the block to the empty-string state
//  in_vld  in   1  in carries a character this cycle; when low the block holds all state
//  in      in   8  ASCII character
//  val_ok  out  1  1 iff the consumed prefix is a legal, complete expression (ends in a digit)
//  val     out  W  value of the prefix when val_ok=1, else 0
//  ovf     out  1  only when EXPR_EVAL_OVF_EN is defined; see CONFIGURATION
// BEHAVIOUR
//  Character classes:
//   - DIG: "0".."9", digit d = in-8'h30
//   - ADD: "+"
//   - MUL: "*"
//   - BAD: any other value
//  State (2b): IDLE=empty, NUM=last char was a digit, OP=last char was an operator, ERR=dead.
//  Datapath registers:
//   - sum (W): committed sum of the finished terms
//   - prod (W): the term being built
//   - mul (1): the pending operator is '*'
//  Reset (clr=1, async): state=IDLE, sum=0, prod=0, mul=0. Outputs: val_ok=0, val=0, ovf=0.
//  With in_vld=0 nothing changes on the edge, including ERR.
//  Transitions on a clk edge with in_vld=1 (registers take the new value on that edge):
//   - IDLE + DIG: state NUM; sum=0; prod=d; mul=0
//   - IDLE + (ADD | MUL | BAD): state ERR
//   - NUM + ADD: state OP; sum=sum+prod; prod=0; mul=0
//   - NUM + MUL: state OP; mul=1; sum and prod unchanged
//   - NUM + (DIG | BAD): state ERR (multi-digit numbers are illegal)
//   - OP + DIG with mul=0: state NUM; prod=d
//   - OP + DIG with mul=1: state NUM; prod=(prod*d)[W-1:0]; mul=0
//   - OP + (ADD | MUL | BAD): state ERR
//   - ERR: absorbing, left only by clr; sum, prod and mul are frozen
//  Outputs are combinational from the registers and have no extra pipeline stage:
//   - val_ok = (state==NUM)
//   - val = val_ok ? (sum+prod)[W-1:0] : 0
//  Latency: the result reflects a character at the same edge that consumes it.
//   - For a given stream, val_ok is identical to the expr validator's out.
//  Widths and overflow:
//   - A product uses the low W bits of (W x 4) and is truncated.
//   - Sums wrap mod 2^W.
//  Edge cases:
//   - clr asserted mid-expression wins over a simultaneous in_vld; the next character is
//     treated as the first character.
//   - A digit "0" is legal. "0*5" gives val=0.
// CONFIGURATION
//  Macro EXPR_EVAL_OVF_EN:
//   - Defined: port ovf exists. ovf is sticky and is cleared only by clr.
//     ovf is set on any edge where sum+prod (on ADD) or prod*d (on MUL-digit) exceeds 2^W-1.
//     ovf also reports as 1 while the combinational val sum exceeds 2^W-1.
//     ovf is not set in ERR.
//   - Undefined: there is no ovf port and no overflow logic; the wrap behaviour is unchanged.
// TESTING
//  1. clr, then "1+2*3" with in_vld=1 -> val_ok 1,0,1,0,1 per char; final val=7.
//  2. "2*3+4*5" -> final val=26, val_ok=1; after "2*3+" val_ok=0 and val=0.
//  3. "+1" -> ERR after the first char. "12" -> ERR after "2". Both stay val_ok=0 for 5
//     more digits; clr then "9" gives val=9.
//  4. "3", in_vld=0 for 4 cycles while in="+", then "*4" -> val stays 3, then final val=12.
//  5. clr pulsed asynchronously mid-stream after "5*" -> val_ok=0 and val=0 immediately;
//     then "7" gives val=7.
//  6. W=8 with EXPR_EVAL_OVF_EN: "9*9*9" -> val=217, ovf=1. clr -> ovf=0.
//     Without the macro the same stream gives val=217.

Source files
------------

// File: rtl/expr_eval.sv
// Arithmetic evaluator for the single-digit "d{[+*]d}" character stream, '*' binding tighter than '+'.
// Optional sticky overflow flag on port ovf when EXPR_EVAL_OVF_EN is defined.
module expr_eval #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         in_vld,
   input  logic [7:0]   in,
   output logic         val_ok,
   output logic [W-1:0] val
`ifdef EXPR_EVAL_OVF_EN
   ,
   output logic         ovf
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      NUM  = 2'd1,
      OP   = 2'd2,
      ERR  = 2'd3
   } state_t;

   state_t       state, state_nxt;
   logic [W-1:0] sum, sum_nxt;
   logic [W-1:0] prod, prod_nxt;
   logic         mul, mul_nxt;

   logic         is_dig, is_add, is_mul;
   logic [3:0]   d;
   logic [W-1:0] add_res, mul_res;

   assign is_dig = (in >= 8'h30) && (in <= 8'h39);
   assign is_add = (in == 8'h2b);
   assign is_mul = (in == 8'h2a);
   // For "0".."9" the low nibble is already the digit value.
   assign d      = in[3:0];

`ifdef EXPR_EVAL_OVF_EN
   logic         ovf_q, ovf_nxt;
   logic [W:0]   add_full;
   logic [W+3:0] mul_full;

   assign add_full = {1'b0, sum} + {1'b0, prod};
   assign mul_full = {4'b0000, prod} * {{W{1'b0}}, d};
   assign add_res  = add_full[W-1:0];
   assign mul_res  = mul_full[W-1:0];
   // Sticky history plus the live carry of the displayed sum.
   assign ovf      = ovf_q | ((state == NUM) & add_full[W]);
`else
   assign add_res  = sum + prod;
   assign mul_res  = prod * W'(d);
`endif

   assign val_ok = (state == NUM);
   assign val    = val_ok ? add_res : '0;

   always_comb begin
      state_nxt = state;
      sum_nxt   = sum;
      prod_nxt  = prod;
      mul_nxt   = mul;
`ifdef EXPR_EVAL_OVF_EN
      ovf_nxt   = ovf_q;
`endif
      if (in_vld) begin
         case (state)
            IDLE: begin
               if (is_dig) begin
                  state_nxt = NUM;
                  sum_nxt   = '0;
                  prod_nxt  = W'(d);
                  mul_nxt   = 1'b0;
               end else begin
                  state_nxt = ERR;
               end
            end
            NUM: begin
               if (is_add) begin
                  state_nxt = OP;
                  sum_nxt   = add_res;
                  prod_nxt  = '0;
                  mul_nxt   = 1'b0;
`ifdef EXPR_EVAL_OVF_EN
                  ovf_nxt   = ovf_q | add_full[W];
`endif
               end else if (is_mul) begin
                  state_nxt = OP;
                  mul_nxt   = 1'b1;
               end else begin
                  state_nxt = ERR;
               end
            end
            OP: begin
               if (is_dig) begin
                  state_nxt = NUM;
                  mul_nxt   = 1'b0;
                  if (mul) begin
                     prod_nxt = mul_res;
`ifdef EXPR_EVAL_OVF_EN
                     ovf_nxt  = ovf_q | (|mul_full[W+3:W]);
`endif
                  end else begin
                     prod_nxt = W'(d);
                  end
               end else begin
                  state_nxt = ERR;
               end
            end
            default: state_nxt = ERR;
         endcase
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state <= IDLE;
         sum   <= '0;
         prod  <= '0;
         mul   <= 1'b0;
`ifdef EXPR_EVAL_OVF_EN
         ovf_q <= 1'b0;
`endif
      end else begin
         state <= state_nxt;
         sum   <= sum_nxt;
         prod  <= prod_nxt;
         mul   <= mul_nxt;
`ifdef EXPR_EVAL_OVF_EN
         ovf_q <= ovf_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_expr_eval.sv
// Scoreboard bench for expr_eval: a W=32 and a W=8 instance share one character stream.
// Stimulus pushes hand-computed expectations; a negedge monitor pops and compares.
module tb_expr_eval;

   typedef struct {
      logic        ok;
      logic [31:0] v32;
      logic [7:0]  v8;
      logic        ovf8;
   } exp_t;

   logic        clk = 1'b0;
   logic        clr;
   logic        in_vld;
   logic [7:0]  in_ch;
   logic        ok32, ok8;
   logic [31:0] val32;
   logic [7:0]  val8;
`ifdef EXPR_EVAL_OVF_EN
   logic        ovf32, ovf8;
`endif

   exp_t exp_q[$];
   int   n_vec  = 0;
   int   n_miss = 0;

   always #5 clk = ~clk;

   expr_eval #(.W(32)) u_d32 (
      .clk(clk), .clr(clr), .in_vld(in_vld), .in(in_ch),
      .val_ok(ok32), .val(val32)
`ifdef EXPR_EVAL_OVF_EN
      , .ovf(ovf32)
`endif
   );

   expr_eval #(.W(8)) u_d8 (
      .clk(clk), .clr(clr), .in_vld(in_vld), .in(in_ch),
      .val_ok(ok8), .val(val8)
`ifdef EXPR_EVAL_OVF_EN
      , .ovf(ovf8)
`endif
   );

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] req);
      if (act !== req) begin
         n_miss++;
         $display("FAIL %s vec %0d: got %0d, want %0d", name, idx, act, req);
      end
   endtask

   // Monitor: one expectation per negedge, sampled away from the active edge.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         n_vec++;
         chk("val_ok32", n_vec, {31'd0, ok32}, {31'd0, e.ok});
         chk("val32",    n_vec, val32,          e.v32);
         chk("val_ok8",  n_vec, {31'd0, ok8},  {31'd0, e.ok});
         chk("val8",     n_vec, {24'd0, val8},  {24'd0, e.v8});
`ifdef EXPR_EVAL_OVF_EN
         chk("ovf32",    n_vec, {31'd0, ovf32}, 32'd0);
         chk("ovf8",     n_vec, {31'd0, ovf8},  {31'd0, e.ovf8});
`endif
      end
   end

   task automatic push(input bit ok, input int unsigned v, input bit o8);
      exp_t e;
      e.ok   = ok;
      e.v32  = v;
      e.v8   = v[7:0];
      e.ovf8 = o8;
      exp_q.push_back(e);
   endtask

   task automatic step(input logic [7:0] ch, input bit vld, input bit ok, input int unsigned v, input bit o8);
      in_ch  = ch;
      in_vld = vld;
      @(posedge clk);
      #1;
      push(ok, v, o8);
   endtask

   task automatic c(input logic [7:0] ch, input bit ok, input int unsigned v);
      step(ch, 1'b1, ok, v, 1'b0);
   endtask

   task automatic co(input logic [7:0] ch, input bit ok, input int unsigned v, input bit o8);
      step(ch, 1'b1, ok, v, o8);
   endtask

   // Async pulse between edges, then clr held over an edge with a live digit.
   task automatic do_clr();
      @(negedge clk);
      #1;
      in_vld = 1'b0;
      clr    = 1'b1;
      #1;
      push(1'b0, 0, 1'b0);
      #1;
      clr = 1'b0;
      @(posedge clk);
      #1;
      clr    = 1'b1;
      in_vld = 1'b1;
      in_ch  = "1";
      @(posedge clk);
      #1;
      push(1'b0, 0, 1'b0);
      #1;
      clr    = 1'b0;
      in_vld = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: run did not finish, vectors %0d", n_vec);
      $fatal(1, "watchdog");
   end

   initial begin
      clr    = 1'b1;
      in_vld = 1'b0;
      in_ch  = 8'h00;
      #1;
      push(1'b0, 0, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1;
      clr = 1'b0;

      // 1+2*3
      c("1", 1, 1); c("+", 0, 0); c("2", 1, 3); c("*", 0, 0); c("3", 1, 7);
      do_clr();
      // 2*3+4*5
      c("2", 1, 2); c("*", 0, 0); c("3", 1, 6); c("+", 0, 0);
      c("4", 1, 10); c("*", 0, 0); c("5", 1, 26);
      do_clr();
      // leading operator, then multi-digit number
      c("+", 0, 0);
      for (int i = 0; i < 5; i++) c("5", 0, 0);
      do_clr();
      c("9", 1, 9);
      do_clr();
      c("1", 1, 1); c("2", 0, 0);
      for (int i = 0; i < 5; i++) c("7", 0, 0);
      c("x", 0, 0);
      do_clr();
      c("9", 1, 9);
      do_clr();
      // in_vld low holds state
      c("3", 1, 3);
      for (int i = 0; i < 4; i++) step("+", 1'b0, 1, 3, 1'b0);
      c("*", 0, 0); c("4", 1, 12);
      do_clr();
      // clear mid-stream after "5*"
      c("5", 1, 5); c("*", 0, 0);
      do_clr();
      c("7", 1, 7);
      do_clr();
      // zero digit
      c("0", 1, 0); c("*", 0, 0); c("5", 1, 0);
      do_clr();
      // 9*9*9: 729, low byte 217, product overflow at W=8
      c("9", 1, 9); c("*", 0, 0); c("9", 1, 81); c("*", 0, 0);
      co("9", 1, 729, 1);
      do_clr();
      // 9*9*3+9*9: live sum carry at W=8, then sticky on '+'
      c("9", 1, 9); c("*", 0, 0); c("9", 1, 81); c("*", 0, 0); c("3", 1, 243);
      c("+", 0, 0); c("9", 1, 252); c("*", 0, 0);
      co("9", 1, 324, 1);
      co("+", 0, 0, 1);
      co("1", 1, 325, 1);
      co("*", 0, 0, 1);
      co("+", 0, 0, 1);
      do_clr();

      repeat (3) @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         n_miss++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
